// File: rtl/vram_arbiter_pkg.sv
// ============================================================================
// Module  : vram_arbiter_pkg
// Brief   : Shared types and defaults for the VRAM arbiter slice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package vram_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam int DEFAULT_RAM_BITS     = 16;
  localparam int DEFAULT_STARVE_LIMIT = 15;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module  : vram_arbiter_if
// Brief   : Display fetch and CPU req/ack bundle between clients and arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int RAM_BITS = DEFAULT_RAM_BITS
);

  logic                disp_req;
  logic [RAM_BITS-1:0] disp_addr;
  logic                disp_valid;
  logic [7:0]          disp_data;
  logic                disp_miss;

  logic                cpu_req;
  logic                cpu_write;
  logic [RAM_BITS-1:0] cpu_addr;
  logic [7:0]          cpu_wdata;
  logic                cpu_ack;
  logic [7:0]          cpu_rdata;
  logic                cpu_starved;

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata, cpu_starved
  );

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata, cpu_starved
  );

endinterface

`default_nettype wire

// File: rtl/vram_starve_counter.sv
// ============================================================================
// Module  : vram_starve_counter
// Brief   : Saturating count of denied CPU cycles with registered starved flag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vram_starve_counter #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);

  logic [7:0] r_count;
  logic [7:0] w_count_next;
  logic       r_starved;

  always_comb begin
    w_count_next = r_count;
    if (clr) begin
      w_count_next = 8'd0;
    end else if (inc && (r_count != c_limit)) begin
      w_count_next = r_count + 8'd1;
    end
  end

  // Flag follows the next count so it is visible in the cycle right after
  // the limiting denied cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 8'd0;
      r_starved <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_starved <= (w_count_next == c_limit);
    end
  end

  assign starved = r_starved;

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module  : vram_arbiter
// Brief   : Single-port VRAM scheduler; display wins, CPU fills idle cycles.
//           Optional macro VRAM_STARVE_OVERRIDE_EN lets a starved CPU win.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int RAM_BITS     = DEFAULT_RAM_BITS,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  vram_arbiter_if.slave       bus,
  output logic [RAM_BITS-1:0] ram_address,
  output logic                ram_write_enabled,
  output logic [7:0]          ram_data_in,
  input  logic [7:0]          ram_data_out
);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_idle;
  logic       w_override;
  logic       w_disp_gnt;
  logic       w_cpu_gnt;
  logic       w_cpu_ack;
  logic       w_ack_read;
  logic       w_starved;
  logic       r_disp_valid;
  logic       r_is_read;
  logic [7:0] r_rdata;

  assign w_idle = (r_state == ST_IDLE);

`ifdef VRAM_STARVE_OVERRIDE_EN
  logic r_disp_miss;
  assign w_override = w_idle & bus.cpu_req & w_starved;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_miss <= 1'b0;
    end else begin
      r_disp_miss <= bus.disp_req & w_override;
    end
  end
  assign bus.disp_miss = r_disp_miss;
`else
  assign w_override    = 1'b0;
  assign bus.disp_miss = 1'b0;
`endif

  assign w_disp_gnt = bus.disp_req & ~w_override;
  assign w_cpu_gnt  = w_idle & bus.cpu_req & (~bus.disp_req | w_override);

  assign ram_address       = w_cpu_gnt ? bus.cpu_addr : bus.disp_addr;
  assign ram_write_enabled = w_cpu_gnt & bus.cpu_write & ~reset;
  assign ram_data_in       = bus.cpu_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cpu_ack    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_cpu_gnt) w_state_next = ST_ACK;
      ST_ACK: begin
        w_cpu_ack    = ~reset;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Read data arrives in the ACK cycle: pass it through alongside the ack,
  // and keep a copy so it stays visible until the next read.
  assign w_ack_read = w_cpu_ack & r_is_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_valid <= 1'b0;
      r_is_read    <= 1'b0;
      r_rdata      <= 8'h00;
    end else begin
      r_disp_valid <= w_disp_gnt;
      if (w_cpu_gnt) r_is_read <= ~bus.cpu_write;
      if (w_ack_read) r_rdata <= ram_data_out;
    end
  end

  vram_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_idle & bus.cpu_req & ~w_cpu_gnt),
    .clr     (~bus.cpu_req | w_cpu_gnt),
    .starved (w_starved)
  );

  assign bus.disp_valid  = r_disp_valid;
  assign bus.disp_data   = ram_data_out;
  assign bus.cpu_ack     = w_cpu_ack;
  assign bus.cpu_rdata   = w_ack_read ? ram_data_out : r_rdata;
  assign bus.cpu_starved = w_starved;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module  : tb_vram_arbiter
// Brief   : Directed self-checking bench for vram_arbiter with a 64KB RAM model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_address;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.RAM_BITS(16)) bus ();

  vram_arbiter #(
    .RAM_BITS     (16),
    .STARVE_LIMIT (15)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .ram_address       (ram_address),
    .ram_write_enabled (ram_we),
    .ram_data_in       (ram_din),
    .ram_data_out      (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_din;
    ram_dout <= mem[ram_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.disp_req = 1'b0; bus.disp_addr = 16'h0000;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", ram_we); end
      n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus.cpu_ack); end
      n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL rst_dvalid: got %b want 0", bus.disp_valid); end
    end
    n_cmp++; if (bus.cpu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", bus.cpu_rdata); end
    n_cmp++; if (bus.cpu_starved !== 1'b0) begin n_err++; $display("FAIL rst_starved: got %b want 0", bus.cpu_starved); end
    n_cmp++; if (bus.disp_miss !== 1'b0) begin n_err++; $display("FAIL rst_miss: got %b want 0", bus.disp_miss); end
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hA5;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", ram_we); end
    n_cmp++; if (ram_address !== 16'h1234) begin n_err++; $display("FAIL wr_addr: got %h want 1234", ram_address); end
    n_cmp++; if (ram_din !== 8'hA5) begin n_err++; $display("FAIL wr_din: got %h want a5", ram_din); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wr_ack_we: got %b want 0", ram_we); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_pulse: got %b want 0", bus.cpu_ack); end
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b want 0", ram_we); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_pulse: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_hold: got %h want a5", bus.cpu_rdata); end
  endtask

  task automatic test_display_priority();
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 8'h3C;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0040;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h1234;
    #1;
    n_cmp++; if (ram_address !== 16'h0040) begin n_err++; $display("FAIL dp_addr: got %h want 0040", ram_address); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL dp_we: got %b want 0", ram_we); end
    tick();
    n_cmp++; if (bus.disp_valid !== 1'b1) begin n_err++; $display("FAIL dp_valid: got %b want 1", bus.disp_valid); end
    n_cmp++; if (bus.disp_data !== 8'h3C) begin n_err++; $display("FAIL dp_data: got %h want 3c", bus.disp_data); end
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL dp_cpu_held: got %b want 0", bus.cpu_ack); end
    bus.disp_req = 1'b0;
    #1;
    n_cmp++; if (ram_address !== 16'h1234) begin n_err++; $display("FAIL dp_cpu_addr: got %h want 1234", ram_address); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL dp_cpu_ack: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL dp_cpu_rdata: got %h want a5", bus.cpu_rdata); end
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL dp_valid_off: got %b want 0", bus.disp_valid); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h11;
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack1: got %b want 1", bus.cpu_ack); end
    bus.cpu_addr = 16'h0011; bus.cpu_wdata = 8'h22;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL b2b_ack_we: got %b want 0", ram_we); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL b2b_gap: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL b2b_we2: got %b want 1", ram_we); end
    n_cmp++; if (ram_address !== 16'h0011) begin n_err++; $display("FAIL b2b_addr2: got %h want 0011", ram_address); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack2: got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    tick();
    n_cmp++; if (mem[16'h0010] !== 8'h11) begin n_err++; $display("FAIL b2b_mem0: got %h want 11", mem[16'h0010]); end
    n_cmp++; if (mem[16'h0011] !== 8'h22) begin n_err++; $display("FAIL b2b_mem1: got %h want 22", mem[16'h0011]); end
  endtask

  task automatic test_withdraw();
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0040;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wd_we: got %b want 0", ram_we); end
      tick();
    end
    bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL wd_ack: got %b want 0", bus.cpu_ack); end
    tick();
    n_cmp++; if (mem[16'h0020] === 8'h77) begin n_err++; $display("FAIL wd_mem: got %h want not 77", mem[16'h0020]); end
    n_cmp++; if (bus.cpu_starved !== 1'b0) begin n_err++; $display("FAIL wd_starved: got %b want 0", bus.cpu_starved); end
  endtask

  task automatic test_starvation();
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0040;
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h1234;
`ifdef VRAM_STARVE_OVERRIDE_EN
    for (int k = 1; k <= 15; k++) begin
      #1;
      n_cmp++; if (bus.cpu_starved !== 1'b0) begin n_err++; $display("FAIL ov_starved_c%0d: got %b want 0", k, bus.cpu_starved); end
      n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL ov_ack_c%0d: got %b want 0", k, bus.cpu_ack); end
      tick();
    end
    n_cmp++; if (bus.cpu_starved !== 1'b1) begin n_err++; $display("FAIL ov_starved16: got %b want 1", bus.cpu_starved); end
    n_cmp++; if (ram_address !== 16'h1234) begin n_err++; $display("FAIL ov_addr16: got %h want 1234", ram_address); end
    tick();
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL ov_dvalid17: got %b want 0", bus.disp_valid); end
    n_cmp++; if (bus.disp_miss !== 1'b1) begin n_err++; $display("FAIL ov_miss17: got %b want 1", bus.disp_miss); end
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL ov_ack17: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL ov_rdata17: got %h want a5", bus.cpu_rdata); end
    n_cmp++; if (bus.cpu_starved !== 1'b0) begin n_err++; $display("FAIL ov_starved17: got %b want 0", bus.cpu_starved); end
    bus.cpu_req = 1'b0;
    tick();
    n_cmp++; if (bus.disp_valid !== 1'b1) begin n_err++; $display("FAIL ov_dvalid18: got %b want 1", bus.disp_valid); end
    n_cmp++; if (bus.disp_miss !== 1'b0) begin n_err++; $display("FAIL ov_miss18: got %b want 0", bus.disp_miss); end
    bus.disp_req = 1'b0;
    tick();
`else
    for (int k = 1; k <= 20; k++) begin
      #1;
      n_cmp++; if (bus.cpu_starved !== (k >= 16)) begin n_err++; $display("FAIL st_starved_c%0d: got %b want %b", k, bus.cpu_starved, (k >= 16)); end
      n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL st_ack_c%0d: got %b want 0", k, bus.cpu_ack); end
      n_cmp++; if (bus.disp_miss !== 1'b0) begin n_err++; $display("FAIL st_miss_c%0d: got %b want 0", k, bus.disp_miss); end
      tick();
    end
    bus.disp_req = 1'b0;
    #1;
    n_cmp++; if (ram_address !== 16'h1234) begin n_err++; $display("FAIL st_addr21: got %h want 1234", ram_address); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL st_ack22: got %b want 1", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_err++; $display("FAIL st_rdata22: got %h want a5", bus.cpu_rdata); end
    n_cmp++; if (bus.cpu_starved !== 1'b0) begin n_err++; $display("FAIL st_starved22: got %b want 0", bus.cpu_starved); end
    bus.cpu_req = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_in_ack();
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 16'h1234;
    tick();
    reset = 1'b1; bus.cpu_req = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL ra_ack_in_reset: got %b want 0", bus.cpu_ack); end
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL ra_ack_after: got %b want 0", bus.cpu_ack); end
    n_cmp++; if (bus.cpu_rdata !== 8'h00) begin n_err++; $display("FAIL ra_rdata: got %h want 00", bus.cpu_rdata); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b0) begin n_err++; $display("FAIL ra_ack_idle: got %b want 0", bus.cpu_ack); end
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 8'h5A;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL ra_idle_grant: got %b want 1", ram_we); end
    tick();
    n_cmp++; if (bus.cpu_ack !== 1'b1) begin n_err++; $display("FAIL ra_new_ack: got %b want 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_display_priority();
    test_back_to_back();
    test_withdraw();
    test_starvation();
    test_reset_in_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
